// File: rtl/spi_flash_txn_scheduler_if.sv
// rtl/spi_flash_txn_scheduler_if.sv - request, data and shifter handshake bundle for the txn scheduler
interface spi_flash_txn_scheduler_if #(
  parameter int LEN_W          = 8,
  parameter int NUM_ADDR_BYTES = 3
);
  logic [1:0]                    req_valid;
  logic [1:0]                    req_rw;
  logic [2*8*NUM_ADDR_BYTES-1:0] req_addr;
  logic [2*LEN_W-1:0]            req_len;
  logic [1:0]                    req_ready;
  logic [7:0]                    wr_data;
  logic                          wr_data_pop;
  logic [7:0]                    rd_data;
  logic                          rd_valid;
  logic                          active_id;
  logic                          busy;
  logic                          cs_n;
  logic                          tx_start;
  logic [7:0]                    tx_byte;
  logic                          tx_done;
  logic [7:0]                    rx_byte;

  // Scheduler side: drives grants, chip select and the shifter start strobe.
  modport master (
    input  req_valid, req_rw, req_addr, req_len, wr_data, tx_done, rx_byte,
    output req_ready, wr_data_pop, rd_data, rd_valid, active_id, busy, cs_n, tx_start, tx_byte
  );

  // Environment side: requesters plus the byte shifter.
  modport slave (
    output req_valid, req_rw, req_addr, req_len, wr_data, tx_done, rx_byte,
    input  req_ready, wr_data_pop, rd_data, rd_valid, active_id, busy, cs_n, tx_start, tx_byte
  );
endinterface

// File: rtl/spi_flash_txn_scheduler.sv
// rtl/spi_flash_txn_scheduler.sv - round-robin SPI flash transaction sequencer sharing one byte shifter
module spi_flash_txn_scheduler #(
  parameter int         LEN_W          = 8,
  parameter int         NUM_ADDR_BYTES = 3,
  parameter int         CS_GAP         = 2,
  parameter logic [7:0] CMD_WREN       = 8'h06,
  parameter logic [7:0] CMD_WRITE      = 8'h02,
  parameter logic [7:0] CMD_READ       = 8'h03
) (
  input logic                        clk,
  input logic                        rst,
  spi_flash_txn_scheduler_if.master  bus
);
  localparam int               AW        = 8 * NUM_ADDR_BYTES;
  localparam int               GAP_W     = $clog2(CS_GAP + 1);
  localparam logic [1:0]       LAST_ADDR = 2'(NUM_ADDR_BYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(CS_GAP - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ISSUE, S_WAIT, S_GAP} state_t;
  typedef enum logic [1:0] {PH_WREN, PH_CMD, PH_ADDR, PH_DATA} phase_t;

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic             rw_q, rw_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [1:0]       aidx_q, aidx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             wren_gap_q, wren_gap_d;
  logic             last_grant_q, last_grant_d;
  logic             active_id_q, active_id_d;
  logic             busy_q, busy_d;
  logic             cs_n_q, cs_n_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             grant;
  logic [1:0]       req_ready;
  logic             tx_start;
  logic [7:0]       tx_byte;
  logic             wr_data_pop;

  // State register; reset forces cs_n high and returns to IDLE immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      phase_q      <= PH_CMD;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      cnt_q        <= '0;
      aidx_q       <= '0;
      gap_q        <= '0;
      wren_gap_q   <= 1'b0;
      last_grant_q <= 1'b1;
      active_id_q  <= 1'b0;
      busy_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      rd_data_q    <= 8'h00;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      aidx_q       <= aidx_d;
      gap_q        <= gap_d;
      wren_gap_q   <= wren_gap_d;
      last_grant_q <= last_grant_d;
      active_id_q  <= active_id_d;
      busy_q       <= busy_d;
      cs_n_q       <= cs_n_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  // Arbitration, byte-phase sequencing and shifter strobes.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    aidx_d       = aidx_q;
    gap_d        = gap_q;
    wren_gap_d   = wren_gap_q;
    last_grant_d = last_grant_q;
    active_id_d  = active_id_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    grant        = 1'b0;
    req_ready    = 2'b00;
    tx_start     = 1'b0;
    tx_byte      = 8'h00;
    wr_data_pop  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|bus.req_valid) begin
          // Prefer the requester that did not win last time; otherwise take whichever is valid.
          grant        = bus.req_valid[~last_grant_q] ? ~last_grant_q : ~bus.req_valid[0];
          req_ready    = 2'b01 << grant;
          rw_d         = bus.req_rw[grant];
          addr_d       = grant ? bus.req_addr[2*AW-1:AW] : bus.req_addr[AW-1:0];
          cnt_d        = grant ? bus.req_len[2*LEN_W-1:LEN_W] : bus.req_len[LEN_W-1:0];
          aidx_d       = LAST_ADDR;
          active_id_d  = grant;
          last_grant_d = grant;
          wren_gap_d   = 1'b0;
          phase_d      = bus.req_rw[grant] ? PH_WREN : PH_CMD;
          state_d      = S_SETUP;
        end
      end
      S_SETUP: state_d = S_ISSUE;
      S_ISSUE: begin
        tx_start = 1'b1;
        case (phase_q)
          PH_WREN: tx_byte = CMD_WREN;
          PH_CMD:  tx_byte = rw_q ? CMD_WRITE : CMD_READ;
          PH_ADDR: tx_byte = addr_q[AW-1 -: 8];
          default: begin
            tx_byte     = rw_q ? bus.wr_data : 8'h00;
            wr_data_pop = rw_q;
          end
        endcase
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.tx_done) begin
          state_d = S_ISSUE;
          case (phase_q)
            PH_WREN: begin
              wren_gap_d = 1'b1;
              state_d    = S_GAP;
            end
            PH_CMD: phase_d = PH_ADDR;
            PH_ADDR: begin
              // Address is shifted out MSB first by walking the register left.
              addr_d = addr_q << 8;
              aidx_d = aidx_q - 2'd1;
              if (aidx_q == 2'd0) begin
                if (cnt_q == '0) state_d = S_GAP;
                else             phase_d = PH_DATA;
              end
            end
            default: begin
              if (!rw_q) begin
                rd_data_d  = bus.rx_byte;
                rd_valid_d = 1'b1;
              end
              cnt_d = cnt_q - LEN_W'(1);
              if (cnt_q == LEN_W'(1)) state_d = S_GAP;
            end
          endcase
          if (state_d == S_GAP) gap_d = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          if (wren_gap_q) begin
            wren_gap_d = 1'b0;
            phase_d    = PH_CMD;
            state_d    = S_SETUP;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Chip select is registered from the next state so it never glitches.
    cs_n_d = !((state_d == S_SETUP) || (state_d == S_ISSUE) || (state_d == S_WAIT));
    busy_d = (state_d != S_IDLE);
  end

  assign bus.req_ready   = req_ready;
  assign bus.wr_data_pop = wr_data_pop;
  assign bus.tx_start    = tx_start;
  assign bus.tx_byte     = tx_byte;
  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.active_id   = active_id_q;
  assign bus.busy        = busy_q;
  assign bus.cs_n        = cs_n_q;
endmodule

// File: tb/tb_spi_flash_txn_scheduler.sv
// tb/tb_spi_flash_txn_scheduler.sv - scoreboard bench for the SPI flash transaction scheduler
`timescale 1ns/1ps
module tb_spi_flash_txn_scheduler;
  localparam int LEN_W  = 8;
  localparam int NAB    = 3;
  localparam int AW     = 8 * NAB;
  localparam int CS_GAP = 2;

  typedef struct packed {
    logic             rw;
    logic [AW-1:0]    addr;
    logic [LEN_W-1:0] len;
  } req_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_flash_txn_scheduler_if #(.LEN_W(LEN_W), .NUM_ADDR_BYTES(NAB)) bus();
  spi_flash_txn_scheduler #(.LEN_W(LEN_W), .NUM_ADDR_BYTES(NAB), .CS_GAP(CS_GAP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  req_t       pend [2][$];
  logic [7:0] wq [2][$];
  logic [7:0] exp_tx[$], exp_rd[$], rx_q[$], rx_script[$], tx_log[$], rd_log[$];
  int         grant_log[$];
  int         exp_windows, windows, exp_pops, pops;
  int         model_last = 1;
  int         model_owner = 0;
  bit         grant_pend_v, pop_pend, sh_busy, stray_req;
  int         grant_pend_id, sh_cnt;
  int         sh_delay_min = 0;
  int         sh_delay_max = 3;
  logic [7:0] sh_rx;
  logic       cs_prev = 1'b1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endfunction

  function automatic void push_byte(input logic [7:0] b, input bit rd);
    logic [7:0] rx;
    if (rd && rx_script.size() != 0) rx = rx_script.pop_front();
    else rx = 8'($urandom);
    exp_tx.push_back(b);
    rx_q.push_back(rx);
    if (rd) exp_rd.push_back(rx);
  endfunction

  // Reference model: byte stream of one flash transaction, built from the command rules.
  function automatic void model_txn(input req_t r, input int id);
    if (r.rw) begin
      push_byte(8'h06, 1'b0);
      exp_windows += 2;
    end else begin
      exp_windows += 1;
    end
    push_byte(r.rw ? 8'h02 : 8'h03, 1'b0);
    for (int k = NAB - 1; k >= 0; k--) push_byte(r.addr[k*8 +: 8], 1'b0);
    for (int k = 0; k < int'(r.len); k++) begin
      if (r.rw) begin
        push_byte(wq[id][k], 1'b0);
        exp_pops++;
      end else begin
        push_byte(8'h00, 1'b1);
      end
    end
  endfunction

  function automatic void refresh();
    for (int i = 0; i < 2; i++) begin
      bus.req_valid[i] = (pend[i].size() != 0);
      bus.req_rw[i]    = (pend[i].size() != 0) ? pend[i][0].rw : 1'b0;
      bus.req_addr[i*AW +: AW]       = (pend[i].size() != 0) ? pend[i][0].addr : '0;
      bus.req_len[i*LEN_W +: LEN_W]  = (pend[i].size() != 0) ? pend[i][0].len : '0;
    end
    bus.wr_data = (wq[model_owner].size() != 0) ? wq[model_owner][0] : 8'h00;
  endfunction

  // Requester and shifter stimulus: updated just after each rising edge.
  initial begin : drv
    bus.tx_done = 1'b0;
    bus.rx_byte = 8'h00;
    refresh();
    forever begin
      @(posedge clk);
      #1;
      if (grant_pend_v) begin
        void'(pend[grant_pend_id].pop_front());
        grant_pend_v = 1'b0;
      end
      if (pop_pend) begin
        void'(wq[model_owner].pop_front());
        pop_pend = 1'b0;
      end
      bus.tx_done = 1'b0;
      if (stray_req) begin
        bus.tx_done = 1'b1;
        bus.rx_byte = 8'hEE;
        stray_req   = 1'b0;
      end else if (sh_busy) begin
        if (sh_cnt == 0) begin
          bus.tx_done = 1'b1;
          bus.rx_byte = sh_rx;
          sh_busy     = 1'b0;
        end else begin
          sh_cnt--;
        end
      end
      refresh();
    end
  end

  // Monitor: pops expectations whenever the DUT presents grants, bytes, pops or read data.
  always @(negedge clk) begin : mon
    int g;
    if (!rst) begin
      if (bus.req_ready != 2'b00) begin
        g = bus.req_valid[model_last ^ 1] ? (model_last ^ 1) : (bus.req_valid[0] ? 0 : 1);
        chk("grant_id", bus.req_ready, 2'b01 << g);
        if (pend[g].size() != 0) model_txn(pend[g][0], g);
        else fail_now("grant_without_request");
        grant_log.push_back(g);
        model_last    = g;
        model_owner   = g;
        grant_pend_v  = 1'b1;
        grant_pend_id = g;
      end
      if (bus.tx_start) begin
        chk("cs_low_at_tx_start", bus.cs_n, 1'b0);
        chk("tx_start_while_shifter_busy", sh_busy, 1'b0);
        if (exp_tx.size() == 0) fail_now("unexpected_tx_start");
        else chk("tx_byte", bus.tx_byte, exp_tx.pop_front());
        tx_log.push_back(bus.tx_byte);
        sh_rx   = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
        sh_busy = 1'b1;
        sh_cnt  = $urandom_range(sh_delay_max, sh_delay_min);
      end
      if (bus.wr_data_pop) begin
        pops++;
        pop_pend = 1'b1;
      end
      if (bus.rd_valid) begin
        if (exp_rd.size() == 0) fail_now("unexpected_rd_valid");
        else chk("rd_data", bus.rd_data, exp_rd.pop_front());
        chk("rd_owner", bus.active_id, model_owner);
        rd_log.push_back(bus.rd_data);
      end
      if (cs_prev && !bus.cs_n) windows++;
    end
    cs_prev = bus.cs_n;
  end

  task automatic clear_logs();
    tx_log.delete();
    rd_log.delete();
    grant_log.delete();
    windows = 0;
    exp_windows = 0;
    pops = 0;
    exp_pops = 0;
  endtask

  task automatic flush_model();
    for (int i = 0; i < 2; i++) begin
      pend[i].delete();
      wq[i].delete();
    end
    exp_tx.delete();
    exp_rd.delete();
    rx_q.delete();
    rx_script.delete();
    grant_pend_v = 1'b0;
    pop_pend     = 1'b0;
    sh_busy      = 1'b0;
    model_last   = 1;
    model_owner  = 0;
    clear_logs();
  endtask

  task automatic check_reset_vals(input string p);
    chk({p, "_cs_n"}, bus.cs_n, 1'b1);
    chk({p, "_tx_start"}, bus.tx_start, 1'b0);
    chk({p, "_tx_byte"}, bus.tx_byte, 8'h00);
    chk({p, "_req_ready"}, bus.req_ready, 2'b00);
    chk({p, "_wr_data_pop"}, bus.wr_data_pop, 1'b0);
    chk({p, "_rd_valid"}, bus.rd_valid, 1'b0);
    chk({p, "_rd_data"}, bus.rd_data, 8'h00);
    chk({p, "_active_id"}, bus.active_id, 1'b0);
    chk({p, "_busy"}, bus.busy, 1'b0);
  endtask

  task automatic do_reset(input string p);
    @(posedge clk);
    #2;
    rst = 1'b1;
    flush_model();
    #1;
    check_reset_vals(p);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    bit idle;
    do begin
      @(negedge clk);
      #1;
      n++;
      idle = (pend[0].size() == 0) && (pend[1].size() == 0) && !grant_pend_v &&
             !bus.busy && (exp_tx.size() == 0) && !sh_busy;
    end while (!idle && n < budget);
    if (!idle) begin
      fail_now({name, "_timeout"});
    end else begin
      chk({name, "_cs_windows"}, windows, exp_windows);
      chk({name, "_pops"}, pops, exp_pops);
      chk({name, "_rd_left"}, exp_rd.size(), 0);
      chk({name, "_cs_n_idle"}, bus.cs_n, 1'b1);
    end
  endtask

  task automatic cmp_log(input string name, input logic [7:0] got[$], input logic [7:0] want[$]);
    chk({name, "_len"}, got.size(), want.size());
    for (int i = 0; i < want.size() && i < got.size(); i++)
      chk($sformatf("%s[%0d]", name, i), got[i], want[i]);
  endtask

  task automatic issue(input int id, input logic rw, input logic [AW-1:0] addr, input int len);
    req_t r;
    r.rw   = rw;
    r.addr = addr;
    r.len  = LEN_W'(len);
    if (rw) for (int k = 0; k < len; k++) wq[id].push_back(8'($urandom));
    pend[id].push_back(r);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin : main
    logic [7:0] want[$];
    int n;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("por");
    @(negedge clk);
    rst = 1'b0;

    // 1: write with WREN window, then CMD/ADDR/DATA window.
    clear_logs();
    wq[0].push_back(8'hA5);
    wq[0].push_back(8'h5A);
    pend[0].push_back('{rw: 1'b1, addr: 24'h012345, len: 8'd2});
    wait_done(2000, "t1");
    want = '{8'h06, 8'h02, 8'h01, 8'h23, 8'h45, 8'hA5, 8'h5A};
    cmp_log("t1_tx", tx_log, want);
    chk("t1_cs_windows_abs", windows, 2);
    chk("t1_pops_abs", pops, 2);
    chk("t1_no_rd", rd_log.size(), 0);
    chk("t1_active_id", bus.active_id, 1'b0);

    // 2: read from requester 1 with scripted receive bytes.
    clear_logs();
    rx_script = '{8'h11, 8'h22, 8'h33};
    issue(1, 1'b0, 24'h00FF10, 3);
    wait_done(2000, "t2");
    want = '{8'h03, 8'h00, 8'hFF, 8'h10, 8'h00, 8'h00, 8'h00};
    cmp_log("t2_tx", tx_log, want);
    want = '{8'h11, 8'h22, 8'h33};
    cmp_log("t2_rd", rd_log, want);
    chk("t2_active_id", bus.active_id, 1'b1);

    // 3: both requesters pending from reset; grants alternate.
    do_reset("t3_rst");
    for (int k = 0; k < 3; k++) begin
      issue(0, 1'($urandom), 24'($urandom), $urandom_range(3, 0));
      issue(1, 1'($urandom), 24'($urandom), $urandom_range(3, 0));
    end
    wait_done(4000, "t3");
    chk("t3_grants", grant_log.size(), 6);
    for (int k = 0; k < 6 && k < grant_log.size(); k++)
      chk($sformatf("t3_grant[%0d]", k), grant_log[k], k % 2);

    // 4: zero-length read: CMD plus address only.
    clear_logs();
    issue(0, 1'b0, 24'hABCDEF, 0);
    wait_done(2000, "t4");
    chk("t4_tx_count", tx_log.size(), 1 + NAB);
    chk("t4_windows_abs", windows, 1);
    chk("t4_no_rd", rd_log.size(), 0);

    // 5: reset while waiting on the first address byte.
    clear_logs();
    sh_delay_min = 30;
    sh_delay_max = 30;
    issue(0, 1'b0, 24'h445566, 2);
    n = 0;
    while (tx_log.size() < 2 && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("t5_reached_addr2", tx_log.size(), 2);
    @(posedge clk);
    #2;
    chk("t5_cs_low_before", bus.cs_n, 1'b0);
    rst = 1'b1;
    #1;
    chk("t5_cs_n_now", bus.cs_n, 1'b1);
    chk("t5_tx_start_now", bus.tx_start, 1'b0);
    chk("t5_rd_valid_now", bus.rd_valid, 1'b0);
    flush_model();
    sh_delay_min = 0;
    sh_delay_max = 3;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stray_req = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("t5_stray_no_tx", tx_log.size(), 0);
    chk("t5_stray_busy", bus.busy, 1'b0);
    chk("t5_stray_cs", bus.cs_n, 1'b1);
    issue(0, 1'b0, 24'h000001, 1);
    wait_done(2000, "t5");
    chk("t5_first_byte", (tx_log.size() != 0) ? tx_log[0] : 8'hXX, 8'h03);

    // 6: slow shifter, 100 cycles per byte.
    clear_logs();
    sh_delay_min = 100;
    sh_delay_max = 100;
    issue(0, 1'b1, 24'h102030, 2);
    wait_done(5000, "t6");
    chk("t6_tx_count", tx_log.size(), 7);
    chk("t6_windows_abs", windows, 2);
    sh_delay_min = 0;
    sh_delay_max = 3;

    // Maximum length in both directions.
    clear_logs();
    issue(1, 1'b0, 24'($urandom), 255);
    issue(0, 1'b1, 24'($urandom), 255);
    wait_done(8000, "maxlen");
    chk("maxlen_rd_count", rd_log.size(), 255);
    chk("maxlen_pop_count", pops, 255);

    // Random batches with contention.
    for (int b = 0; b < 10; b++) begin
      clear_logs();
      for (int t = 0; t < int'($urandom_range(4, 1)); t++)
        issue($urandom_range(1, 0), 1'($urandom), 24'($urandom), $urandom_range(5, 0));
      wait_done(4000, $sformatf("rand%0d", b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
